// File: rtl/riscv_pkg.sv
// Shared definitions for the pipelined RISC-V core: datapath width,
// branch funct3 encodings and control-bundle bit positions.
package riscv_pkg;

    localparam int XLEN_DEF = 64;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    // ex_ctrl is {branch, mem_read, mem_write, mem_to_reg, reg_write};
    // mem_ctrl drops the branch bit and keeps the lower four.
    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_TO_REG = 1;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_MEM_READ   = 3;
    localparam int CTRL_BRANCH     = 4;

    localparam int EX_CTRL_W  = 5;
    localparam int MEM_CTRL_W = 4;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch resolver: turns the ALU flags into a taken/not-taken
// decision for beq/bne/blt/bge. Reused by the hazard unit.
module branch_cmp
    import riscv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       branch,
    input  logic       zero,
    input  logic       less,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        if (branch) begin
            case (funct3)
                F3_BEQ:  taken = zero;
                F3_BNE:  taken = !zero;
                F3_BLT:  taken = less;
                F3_BGE:  taken = !less;
                default: taken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU result and control, resolves
// branches, produces the registered fetch redirect and branch counters.
module ex_mem_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic [XLEN-1:0]       ex_pc,
    input  logic [XLEN-1:0]       ex_imm,
    input  logic [XLEN-1:0]       ex_rs2_data,
    input  logic [4:0]            ex_rd,
    input  logic [2:0]            ex_funct3,
    input  logic [EX_CTRL_W-1:0]  ex_ctrl,
    input  logic [XLEN-1:0]       alu_result,
    input  logic                  alu_zero,
    input  logic                  alu_less,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  mem_valid,
    output logic [XLEN-1:0]       mem_alu_result,
    output logic [XLEN-1:0]       mem_write_data,
    output logic [4:0]            mem_rd,
    output logic [2:0]            mem_funct3,
    output logic [MEM_CTRL_W-1:0] mem_ctrl,
    output logic [XLEN-1:0]       mem_branch_target,
    output logic                  redirect,
    output logic [CNT_W-1:0]      branch_count,
    output logic [CNT_W-1:0]      taken_count
);

    // mem_valid qualifies every mem_* field; the only back-pressure is stall,
    // and a flush replaces the stage contents with a bubble.
    logic                  ex_taken;
    logic [XLEN-1:0]       ex_target;
    logic                  ex_is_branch;

    logic                  valid_q,  valid_d;
    logic                  taken_q,  taken_d;
    logic [MEM_CTRL_W-1:0] ctrl_q,   ctrl_d;
    logic [XLEN-1:0]       result_q, result_d;
    logic [XLEN-1:0]       wdata_q,  wdata_d;
    logic [XLEN-1:0]       target_q, target_d;
    logic [4:0]            rd_q,     rd_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [CNT_W-1:0]      bcnt_q,   bcnt_d;
    logic [CNT_W-1:0]      tcnt_q,   tcnt_d;

    branch_cmp u_branch_cmp (
        .funct3 (ex_funct3),
        .branch (ex_ctrl[CTRL_BRANCH]),
        .zero   (alu_zero),
        .less   (alu_less),
        .taken  (ex_taken)
    );

    // Immediate is in halfword units; the sum wraps modulo 2^XLEN.
    assign ex_target    = ex_pc + (ex_imm << 1);
    assign ex_is_branch = ex_valid & ex_ctrl[CTRL_BRANCH];

    always_comb begin
        valid_d  = valid_q;
        taken_d  = taken_q;
        ctrl_d   = ctrl_q;
        result_d = result_q;
        wdata_d  = wdata_q;
        target_d = target_q;
        rd_d     = rd_q;
        funct3_d = funct3_q;
        bcnt_d   = bcnt_q;
        tcnt_d   = tcnt_q;
        if (flush) begin
            // Data fields are left alone; only the qualifiers are cleared.
            valid_d = 1'b0;
            taken_d = 1'b0;
            ctrl_d  = '0;
        end else if (!stall) begin
            valid_d  = ex_valid;
            taken_d  = ex_valid & ex_taken;
            ctrl_d   = ex_valid ? ex_ctrl[MEM_CTRL_W-1:0] : '0;
            result_d = alu_result;
            wdata_d  = ex_rs2_data;
            target_d = ex_target;
            rd_d     = ex_rd;
            funct3_d = ex_funct3;
            if (ex_is_branch) begin
                bcnt_d = bcnt_q + CNT_W'(1);
                if (ex_taken) begin
                    tcnt_d = tcnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            taken_q  <= 1'b0;
            ctrl_q   <= '0;
            result_q <= '0;
            wdata_q  <= '0;
            target_q <= '0;
            rd_q     <= '0;
            funct3_q <= '0;
            bcnt_q   <= '0;
            tcnt_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            taken_q  <= taken_d;
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
            wdata_q  <= wdata_d;
            target_q <= target_d;
            rd_q     <= rd_d;
            funct3_q <= funct3_d;
            bcnt_q   <= bcnt_d;
            tcnt_q   <= tcnt_d;
        end
    end

    assign mem_valid         = valid_q;
    assign mem_alu_result    = result_q;
    assign mem_write_data    = wdata_q;
    assign mem_rd            = rd_q;
    assign mem_funct3        = funct3_q;
    assign mem_ctrl          = ctrl_q;
    assign mem_branch_target = target_q;
    assign redirect          = valid_q & taken_q;
    assign branch_count      = bcnt_q;
    assign taken_count       = tcnt_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: each driven cycle pushes its hand-computed
// post-edge outputs; a negedge monitor pops and compares them.
module tb_ex_mem_stage;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic [63:0] ex_pc;
    logic [63:0] ex_imm;
    logic [63:0] ex_rs2_data;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_ctrl;
    logic [63:0] alu_result;
    logic        alu_zero;
    logic        alu_less;
    logic        stall;
    logic        flush;
    logic        mem_valid;
    logic [63:0] mem_alu_result;
    logic [63:0] mem_write_data;
    logic [4:0]  mem_rd;
    logic [2:0]  mem_funct3;
    logic [3:0]  mem_ctrl;
    logic [63:0] mem_branch_target;
    logic        redirect;
    logic [31:0] branch_count;
    logic [31:0] taken_count;

    typedef struct packed {
        logic        valid;
        logic        redirect;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic [63:0] res;
        logic [63:0] wdata;
        logic [63:0] target;
        logic [31:0] bc;
        logic [31:0] tc;
        logic        chk_data;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    ex_mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ex_valid          (ex_valid),
        .ex_pc             (ex_pc),
        .ex_imm            (ex_imm),
        .ex_rs2_data       (ex_rs2_data),
        .ex_rd             (ex_rd),
        .ex_funct3         (ex_funct3),
        .ex_ctrl           (ex_ctrl),
        .alu_result        (alu_result),
        .alu_zero          (alu_zero),
        .alu_less          (alu_less),
        .stall             (stall),
        .flush             (flush),
        .mem_valid         (mem_valid),
        .mem_alu_result    (mem_alu_result),
        .mem_write_data    (mem_write_data),
        .mem_rd            (mem_rd),
        .mem_funct3        (mem_funct3),
        .mem_ctrl          (mem_ctrl),
        .mem_branch_target (mem_branch_target),
        .redirect          (redirect),
        .branch_count      (branch_count),
        .taken_count       (taken_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [4:0] ctrl, input logic [2:0] f3,
                         input logic [63:0] pc, input logic [63:0] imm,
                         input logic [63:0] res, input logic z, input logic l,
                         input logic st, input logic fl);
        ex_valid    = v;
        ex_ctrl     = ctrl;
        ex_funct3   = f3;
        ex_pc       = pc;
        ex_imm      = imm;
        alu_result  = res;
        alu_zero    = z;
        alu_less    = l;
        stall       = st;
        flush       = fl;
        ex_rd       = 5'd0;
        ex_rs2_data = 64'd0;
    endtask

    task automatic expect_out(input logic v, input logic rdir, input logic [3:0] ctrl,
                              input logic [4:0] rd, input logic [63:0] res,
                              input logic [63:0] wdata, input logic [63:0] target,
                              input logic [31:0] bc, input logic [31:0] tc,
                              input logic chk);
        exp_t e;
        e.valid    = v;
        e.redirect = rdir;
        e.ctrl     = ctrl;
        e.rd       = rd;
        e.res      = res;
        e.wdata    = wdata;
        e.target   = target;
        e.bc       = bc;
        e.tc       = tc;
        e.chk_data = chk;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("mem_valid",    64'(mem_valid),    64'(e.valid));
            check("redirect",     64'(redirect),     64'(e.redirect));
            check("mem_ctrl",     64'(mem_ctrl),     64'(e.ctrl));
            check("branch_count", 64'(branch_count), 64'(e.bc));
            check("taken_count",  64'(taken_count),  64'(e.tc));
            if (e.chk_data) begin
                check("mem_rd",            64'(mem_rd),    64'(e.rd));
                check("mem_alu_result",    mem_alu_result, e.res);
                check("mem_write_data",    mem_write_data, e.wdata);
                check("mem_branch_target", mem_branch_target, e.target);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        drive(1'b0, 5'd0, 3'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset with random inputs, including random stall/flush.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                  {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)},
                  {32'($urandom), 32'($urandom)}, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            ex_rd       = 5'($urandom_range(1, 31));
            ex_rs2_data = {32'($urandom), 32'($urandom)};
            expect_out(0, 0, 4'h0, 5'd0, 64'd0, 64'd0, 64'd0, 0, 0, 1);
            tick();
        end

        reset = 1'b1;
        drive(1'b0, 5'd0, 3'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out(0, 0, 4'h0, 5'd0, 64'd0, 64'd0, 64'd0, 0, 0, 0);
        tick();

        // beq taken: 0x100 + (8<<1) = 0x110
        drive(1'b1, 5'b10000, 3'b000, 64'h100, 64'h8, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out(1, 1, 4'h0, 5'd0, 64'd0, 64'd0, 64'h110, 1, 1, 1);
        tick();

        // blt taken: 0x200 + 0x40 = 0x240
        drive(1'b1, 5'b10000, 3'b100, 64'h200, 64'h20, 64'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_out(1, 1, 4'h0, 5'd0, 64'd1, 64'd0, 64'h240, 2, 2, 1);
        tick();

        // bge not taken (less=1): 0x300 + (-4<<1) = 0x2F8
        drive(1'b1, 5'b10000, 3'b101, 64'h300, 64'hFFFF_FFFF_FFFF_FFFC, 64'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_out(1, 0, 4'h0, 5'd0, 64'd1, 64'd0, 64'h2F8, 3, 2, 1);
        tick();

        // bne taken (zero=0): 0x400 + 0x20 = 0x420
        drive(1'b1, 5'b10000, 3'b001, 64'h400, 64'h10, 64'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out(1, 1, 4'h0, 5'd0, 64'd7, 64'd0, 64'h420, 4, 3, 1);
        tick();

        // Unsupported funct3 with branch=1: counted, never taken.
        drive(1'b1, 5'b10000, 3'b010, 64'h0, 64'h0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_out(1, 0, 4'h0, 5'd0, 64'd0, 64'd0, 64'h0, 5, 3, 1);
        tick();

        // Target wrap: 0x..FFF0 + 0x20 = 0x10
        drive(1'b1, 5'b10000, 3'b000, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out(1, 1, 4'h0, 5'd0, 64'd0, 64'd0, 64'h10, 6, 4, 1);
        tick();

        // Stall holds redirect high.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 5'b10000, 3'b001, 64'h900, 64'h4, 64'd3, 1'b0, 1'b0, 1'b1, 1'b0);
            expect_out(1, 1, 4'h0, 5'd0, 64'd0, 64'd0, 64'h10, 6, 4, 1);
            tick();
        end

        // ALU op with reg_write, then 3 stall cycles with different inputs.
        drive(1'b1, 5'b00001, 3'b000, 64'h500, 64'h0, 64'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        ex_rd       = 5'd5;
        ex_rs2_data = 64'hDEAD_BEEF;
        expect_out(1, 0, 4'h1, 5'd5, 64'h55, 64'hDEAD_BEEF, 64'h500, 6, 4, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'b10110, 3'b000, 64'h700, 64'h8, 64'hAA, 1'b1, 1'b0, 1'b1, 1'b0);
            expect_out(1, 0, 4'h1, 5'd5, 64'h55, 64'hDEAD_BEEF, 64'h500, 6, 4, 1);
            tick();
        end

        // Stall and flush together: flush wins, counters unchanged.
        drive(1'b1, 5'b10001, 3'b000, 64'h700, 64'h8, 64'hAA, 1'b1, 1'b0, 1'b1, 1'b1);
        expect_out(0, 0, 4'h0, 5'd0, 64'd0, 64'd0, 64'd0, 6, 4, 0);
        tick();

        // Bubble carrying garbage control.
        drive(1'b0, 5'b11111, 3'b000, 64'h800, 64'h8, 64'h1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out(0, 0, 4'h0, 5'd0, 64'd0, 64'd0, 64'd0, 6, 4, 0);
        tick();

        // Taken branch, then flush while redirect is high.
        drive(1'b1, 5'b10000, 3'b000, 64'h1000, 64'h100, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out(1, 1, 4'h0, 5'd0, 64'd0, 64'd0, 64'h1200, 7, 5, 1);
        tick();
        drive(1'b1, 5'b10000, 3'b000, 64'h2000, 64'h4, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_out(0, 0, 4'h0, 5'd0, 64'd0, 64'd0, 64'd0, 7, 5, 0);
        tick();

        // Mid-stream reset with stall and flush active.
        drive(1'b1, 5'b11001, 3'b100, 64'h40, 64'h2, 64'h9, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_out(1, 1, 4'h9, 5'd0, 64'h9, 64'd0, 64'h44, 8, 6, 1);
        tick();
        reset = 1'b0;
        drive(1'b1, 5'b11001, 3'b100, 64'h40, 64'h2, 64'h9, 1'b0, 1'b1, 1'b1, 1'b1);
        expect_out(0, 0, 4'h0, 5'd0, 64'd0, 64'd0, 64'd0, 0, 0, 1);
        tick();
        reset = 1'b1;
        drive(1'b0, 5'd0, 3'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out(0, 0, 4'h0, 5'd0, 64'd0, 64'd0, 64'd0, 0, 0, 0);
        tick();

        // Bounded drain of the expected queue.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

EX/MEM pipeline stage directly downstream of the 64-bit ALU in the pipelined RISC-V core. Each cycle it captures the ALU result and flags (`zero`, `less`) with the instruction's EX-side control and data, and resolves conditional branches (beq/bne/blt/bge). It also computes the branch target and produces the registered redirect that the fetch stage consumes. It implements pipeline stall, flush and bubble semantics, and keeps two branch performance counters.

## Interface
Parameters:
- `XLEN`, default 64: datapath width.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- `ex_valid`  in  1  the EX stage holds a real instruction.
- `ex_pc`  in  XLEN  PC of the EX instruction.
- `ex_imm`  in  XLEN  sign-extended immediate, not yet shifted.
- `ex_rs2_data`  in  XLEN  store data, already forwarded.
- `ex_rd`  in  5  destination register.
- `ex_funct3`  in  3  branch/memory funct3.
- `ex_ctrl`  in  5  `{branch, mem_read, mem_write, mem_to_reg, reg_write}`.
- `alu_result`  in  XLEN  ALU `Result`.
- `alu_zero`  in  1  ALU zero flag (`Result == 0`).
- `alu_less`  in  1  ALU less flag (`Result[63]`).
- `stall`  in  1  hold the stage contents.
- `flush`  in  1  load a bubble.
- `mem_valid`  out  1  the stage holds a real instruction.
- `mem_alu_result`  out  XLEN  registered ALU result.
- `mem_write_data`  out  XLEN  registered `ex_rs2_data`.
- `mem_rd`  out  5  registered destination register.
- `mem_funct3`  out  3  registered funct3.
- `mem_ctrl`  out  4  `{mem_read, mem_write, mem_to_reg, reg_write}`, forced to 0 when `mem_valid` is 0.
- `mem_branch_target`  out  XLEN  registered branch target.
- `redirect`  out  1  `mem_valid & mem_branch_taken`; fetch takes `mem_branch_target`.
- `branch_count`  out  CNT_W  number of branches that have entered the stage.
- `taken_count`  out  CNT_W  number of taken branches that have entered the stage.

## Operation
- Branch decision is combinational in EX and registered as `mem_branch_taken`. It requires `ex_ctrl.branch = 1`:
  - funct3 000 (beq): taken = `alu_zero`.
  - funct3 001 (bne): taken = `!alu_zero`.
  - funct3 100 (blt): taken = `alu_less`.
  - funct3 101 (bge): taken = `!alu_less`.
  - any other funct3: not taken.
- Target = `ex_pc + (ex_imm << 1)`, truncated to XLEN bits so it wraps modulo 2^64. The target is registered for every instruction; it is meaningful only when `redirect` is 1.
- Update priority on each edge:
  1. `reset` low: every output and counter clears to 0.
  2. `flush`: load a bubble. `mem_valid`, `mem_ctrl` and `mem_branch_taken` clear to 0; the data fields may load anything.
  3. `stall`: all registers and counters hold.
  4. Otherwise: load the EX inputs, with `mem_valid = ex_valid`.
- `ex_valid = 0` is a bubble: `mem_ctrl` and `mem_branch_taken` are loaded as 0, whatever values the control inputs carry.
- `redirect` also requests a flush of IF/ID/EX. That flush is generated by the hazard unit, not by this block. If `flush` is asserted while `redirect` is high, the redirecting instruction still leaves on the next edge.
- Counters: on a normal load with `ex_valid & ex_ctrl.branch`, `branch_count` increments by 1, and `taken_count` also increments if the branch is taken. Counters wrap at 2^CNT_W and do not change on stall, flush or bubble.

## Timing
- Latency 1 cycle: EX inputs at edge N appear on the `mem_*` outputs after edge N.
- `redirect` is purely a function of registered state and is glitch-free for fetch.
- With `stall` held for k cycles, the outputs stay constant for k cycles, including `redirect`.
- Simultaneous `stall` and `flush`: flush wins.
- Reset asserted mid-stream: the next edge yields `mem_valid = 0`, `redirect = 0` and counters = 0, regardless of `stall` or `flush`.
- No combinational path runs from any input to any output.

## Structure
- Shared package `riscv_pkg`:
  - funct3 constants `F3_BEQ`, `F3_BNE`, `F3_BLT`, `F3_BGE`.
  - Control-bit index constants for the `ex_ctrl`/`mem_ctrl` bit positions.
  - The `XLEN` default.
- Sub-module `branch_cmp`: combinational; takes `funct3`, `branch`, `zero` and `less`, and returns `taken`. The hazard unit reuses it later for early-branch experiments.
- Top level: the registers, the priority mux, the target adder and the counters.

## Test plan
- Reset: hold `reset` = 0 for 2 cycles with random inputs → all outputs are 0; after release, `branch_count` = 0.
- beq taken: `ex_valid` = 1, branch = 1, funct3 = 000, `alu_zero` = 1, `ex_pc` = 0x100, `ex_imm` = 0x8 → next cycle `redirect` = 1, target = 0x110, `branch_count` = 1, `taken_count` = 1.
- blt/bge: `alu_less` = 1, with funct3 = 100 and then 101 → `redirect` = 1, then 0; counters end at 2 and 1.
- Wrap: `ex_pc` = 0xFFFF_FFFF_FFFF_FFF0, `ex_imm` = 0x10 → target = 0x0000_0000_0000_0010.
- Stall/flush: load an ALU op with `alu_result` = 0x55 and reg_write = 1, then assert `stall` for 3 cycles → outputs hold 0x55. Then assert `stall` and `flush` together → `mem_valid` = 0, `mem_ctrl` = 0, counters unchanged.
- Bubble with garbage: `ex_valid` = 0, branch = 1, `alu_zero` = 1 → `redirect` = 0, `mem_ctrl` = 0, counters unchanged.
